// File: rtl/udt_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// udt_tx_arbiter_if
//
// One packet stream into or out of the UDT transmit arbiter. It carries an
// AXI-stream style beat plus the UDP destination that goes with the packet.
//
// Signals:
//   tdata[63:0]     beat data
//   tkeep[7:0]      byte enables
//   tvalid          beat valid
//   tlast           last beat of packet
//   tready          sink ready
//   ip_dest[31:0]   destination IP (sampled with the first beat)
//   port_dest[15:0] destination UDP port (sampled with the first beat)
//
// Modports:
//   master : the side that drives the beat and the destination, and receives tready
//   slave  : the side that consumes the beat and drives tready
// ---------------------------------------------------------------------------
interface udt_tx_arbiter_if;

    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tvalid;
    logic        tlast;
    logic        tready;
    logic [31:0] ip_dest;
    logic [15:0] port_dest;

    modport master (
        output tdata,
        output tkeep,
        output tvalid,
        output tlast,
        output ip_dest,
        output port_dest,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tvalid,
        input  tlast,
        input  ip_dest,
        input  port_dest,
        output tready
    );

endinterface

// File: rtl/udt_tx_arbiter.sv
// ---------------------------------------------------------------------------
// udt_tx_arbiter
//
// Packet-level arbiter that shares the single UDP transmit stream between two
// sources. The control source carries the merged handshake, ACK, ACK2, NAK
// and keep-alive packets. The data source carries data packets. Whole
// packets are granted, so beats from two packets are never interleaved.
// Control wins ties. After MAX_CTRL_BURST back-to-back control grants made
// while data was waiting, data gets the next grant, so data cannot starve.
//
// Parameters:
//   MAX_CTRL_BURST  consecutive control grants allowed while data waits (1..15)
//   CNT_WIDTH       width of the completed-packet counters
//
// Ports:
//   core_clk, core_rst_n  clock, synchronous active-low reset
//   arb_enable            1 = new grants allowed; 0 = finish packet, then idle
//   ctrl  (slave)         control packet stream plus destination
//   data  (slave)         data packet stream plus destination
//   out   (master)        merged stream plus the latched destination
//   grant_ctrl/grant_data which source currently owns the output
//   ctrl_pkt_cnt          completed control packets (wraps)
//   data_pkt_cnt          completed data packets (wraps)
// ---------------------------------------------------------------------------
module udt_tx_arbiter #(
    parameter int unsigned MAX_CTRL_BURST = 4,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                   core_clk,
    input  logic                   core_rst_n,
    input  logic                   arb_enable,

    udt_tx_arbiter_if.slave        ctrl,
    udt_tx_arbiter_if.slave        data,
    udt_tx_arbiter_if.master       out,

    output logic                   grant_ctrl,
    output logic                   grant_data,
    output logic [CNT_WIDTH-1:0]   ctrl_pkt_cnt,
    output logic [CNT_WIDTH-1:0]   data_pkt_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StCtrl,
        StData
    } state_e;

    // The burst limit never exceeds 15, so 4 bits are enough.
    typedef logic [3:0] burst_t;
    localparam burst_t MaxBurst = burst_t'(MAX_CTRL_BURST);

    state_e               state_q, state_d;
    burst_t               burst_q, burst_d;
    logic [31:0]          ip_q, ip_d;
    logic [15:0]          port_q, port_d;
    logic [CNT_WIDTH-1:0] ctrl_cnt_q, ctrl_cnt_d;
    logic [CNT_WIDTH-1:0] data_cnt_q, data_cnt_d;

    logic ctrl_wins;
    logic ctrl_end;
    logic data_end;

    // Control may take the output unless data is waiting and control has
    // already used up its burst allowance.
    assign ctrl_wins = ctrl.tvalid && (!data.tvalid || (burst_q < MaxBurst));

    // An output handshake on the last beat closes the granted packet.
    assign ctrl_end  = ctrl.tvalid && ctrl.tlast && out.tready;
    assign data_end  = data.tvalid && data.tlast && out.tready;

    // -----------------------------------------------------------------------
    // Next-state logic and grant-time side effects
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        burst_d    = burst_q;
        ip_d       = ip_q;
        port_d     = port_q;
        ctrl_cnt_d = ctrl_cnt_q;
        data_cnt_d = data_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (arb_enable) begin
                    if (ctrl_wins) begin
                        state_d = StCtrl;
                        ip_d    = ctrl.ip_dest;
                        port_d  = ctrl.port_dest;
                        // The burst only counts while data is actually waiting.
                        if (!data.tvalid) begin
                            burst_d = '0;
                        end else if (burst_q < MaxBurst) begin
                            burst_d = burst_q + 1'b1;
                        end
                    end else if (data.tvalid) begin
                        state_d = StData;
                        ip_d    = data.ip_dest;
                        port_d  = data.port_dest;
                        burst_d = '0;
                    end
                end
            end
            StCtrl: begin
                if (ctrl_end) begin
                    state_d    = StIdle;
                    ctrl_cnt_d = ctrl_cnt_q + 1'b1;
                end
            end
            StData: begin
                if (data_end) begin
                    state_d    = StIdle;
                    data_cnt_d = data_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Zero-latency forwarding mux. Nothing is forwarded while idle.
    // -----------------------------------------------------------------------
    always_comb begin
        out.tdata   = '0;
        out.tkeep   = '0;
        out.tvalid  = 1'b0;
        out.tlast   = 1'b0;
        ctrl.tready = 1'b0;
        data.tready = 1'b0;
        grant_ctrl  = 1'b0;
        grant_data  = 1'b0;

        unique case (state_q)
            StCtrl: begin
                out.tdata   = ctrl.tdata;
                out.tkeep   = ctrl.tkeep;
                out.tvalid  = ctrl.tvalid;
                out.tlast   = ctrl.tlast;
                ctrl.tready = out.tready;
                grant_ctrl  = 1'b1;
            end
            StData: begin
                out.tdata   = data.tdata;
                out.tkeep   = data.tkeep;
                out.tvalid  = data.tvalid;
                out.tlast   = data.tlast;
                data.tready = out.tready;
                grant_data  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Destination stays latched from grant until the next grant.
    assign out.ip_dest   = ip_q;
    assign out.port_dest = port_q;
    assign ctrl_pkt_cnt  = ctrl_cnt_q;
    assign data_pkt_cnt  = data_cnt_q;

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge core_clk) begin
        if (!core_rst_n) begin
            state_q    <= StIdle;
            burst_q    <= '0;
            ip_q       <= '0;
            port_q     <= '0;
            ctrl_cnt_q <= '0;
            data_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            burst_q    <= burst_d;
            ip_q       <= ip_d;
            port_q     <= port_d;
            ctrl_cnt_q <= ctrl_cnt_d;
            data_cnt_q <= data_cnt_d;
        end
    end

endmodule

// File: tb/tb_udt_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_udt_tx_arbiter
//
// Directed bench for udt_tx_arbiter (MAX_CTRL_BURST=4, CNT_WIDTH=32).
// Inputs change just after the falling edge. Outputs are sampled 1 ns later,
// which is well away from the rising edge where the state updates.
// ---------------------------------------------------------------------------
module tb_udt_tx_arbiter;

    logic        core_clk   = 1'b0;
    logic        core_rst_n = 1'b0;
    logic        arb_enable = 1'b0;
    logic        grant_ctrl;
    logic        grant_data;
    logic [31:0] ctrl_pkt_cnt;
    logic [31:0] data_pkt_cnt;

    udt_tx_arbiter_if ctrl_if ();
    udt_tx_arbiter_if data_if ();
    udt_tx_arbiter_if out_if ();

    udt_tx_arbiter #(
        .MAX_CTRL_BURST (4),
        .CNT_WIDTH      (32)
    ) dut (
        .core_clk     (core_clk),
        .core_rst_n   (core_rst_n),
        .arb_enable   (arb_enable),
        .ctrl         (ctrl_if),
        .data         (data_if),
        .out          (out_if),
        .grant_ctrl   (grant_ctrl),
        .grant_data   (grant_data),
        .ctrl_pkt_cnt (ctrl_pkt_cnt),
        .data_pkt_cnt (data_pkt_cnt)
    );

    always #5 core_clk = ~core_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // One cycle of stimulus together with the outputs expected in that cycle.
    // Flags are ordered {grant_ctrl, grant_data, out_tvalid, out_tlast,
    // ctrl_tready, data_tready}.
    typedef struct {
        logic        en;
        logic        cv;
        logic        cl;
        logic        dv;
        logic        dl;
        logic        rdy;
        logic [63:0] cd;
        logic [63:0] dd;
        logic [5:0]  e_flags;
        logic [63:0] e_od;
    } vec_t;

    vec_t        vecs [0:7];
    logic [63:0] beats [0:4];

    localparam logic [63:0] C1 = 64'hC1C1_0000_0000_0001;
    localparam logic [63:0] C2 = 64'hC2C2_0000_0000_0002;
    localparam logic [63:0] D1 = 64'hD1D1_0000_0000_0001;
    localparam logic [63:0] D2 = 64'hD2D2_0000_0000_0002;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic quiet();
        ctrl_if.tvalid    = 1'b0;
        ctrl_if.tlast     = 1'b0;
        ctrl_if.tdata     = '0;
        ctrl_if.tkeep     = 8'hFF;
        ctrl_if.ip_dest   = '0;
        ctrl_if.port_dest = '0;
        data_if.tvalid    = 1'b0;
        data_if.tlast     = 1'b0;
        data_if.tdata     = '0;
        data_if.tkeep     = 8'h0F;
        data_if.ip_dest   = '0;
        data_if.port_dest = '0;
    endtask

    function automatic logic [5:0] flags_now();
        return {grant_ctrl, grant_data, out_if.tvalid, out_if.tlast,
                ctrl_if.tready, data_if.tready};
    endfunction

    initial begin
        int    bi;
        int    gcycles;
        int    ng;
        int    done_n;
        string seq;

        beats[0] = 64'h1111_1111_1111_1111;
        beats[1] = 64'h2222_2222_2222_2222;
        beats[2] = 64'h3333_3333_3333_3333;
        beats[3] = 64'h4444_4444_4444_4444;
        beats[4] = 64'h5555_5555_5555_5555;

        //               en    cv    cl    dv    dl    rdy   cd     dd     flags      od
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, C1,    D1,    6'b000000, 64'h0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, C1,    D1,    6'b101010, C1};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, C2,    D1,    6'b101110, C2};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0, D1,    6'b000000, 64'h0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0, D1,    6'b011001, D1};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 64'h0, 6'b010001, 64'h0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h0, D2,    6'b011101, D2};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 64'h0, 6'b000000, 64'h0};

        // ---------------- reset state ----------------
        quiet();
        out_if.tready = 1'b0;
        repeat (2) @(negedge core_clk);
        #1;
        check("reset flags", 64'(flags_now()), 64'h0);
        check("reset tdata", out_if.tdata, 64'h0);
        check("reset cnts", {ctrl_pkt_cnt, data_pkt_cnt}, 64'h0);

        // ---------------- basic 3-beat data packet ----------------
        @(negedge core_clk);
        core_rst_n    = 1'b1;
        arb_enable    = 1'b1;
        out_if.tready = 1'b1;
        bi      = 0;
        gcycles = 0;
        for (int n = 0; n < 12 && bi < 3; n++) begin
            if (n != 0) @(negedge core_clk);
            data_if.tvalid    = 1'b1;
            data_if.tdata     = beats[bi];
            data_if.tlast     = (bi == 2);
            // Scramble the destination once granted: the latched copy must hold.
            data_if.ip_dest   = grant_data ? 32'hDEAD_BEEF : 32'hC0A8_0002;
            data_if.port_dest = grant_data ? 16'hFFFF : 16'd9000;
            #1;
            if (grant_data) gcycles++;
            if (out_if.tvalid && out_if.tready) begin
                check("basic beat", out_if.tdata, beats[bi]);
                check("basic keep/last", 64'({out_if.tkeep, out_if.tlast}),
                      64'({8'h0F, (bi == 2)}));
                check("basic ip/port", 64'({out_if.ip_dest, out_if.port_dest}),
                      64'({32'hC0A8_0002, 16'd9000}));
                bi++;
            end
        end
        check("basic beats done", 64'(bi), 64'd3);
        @(negedge core_clk);
        quiet();
        #1;
        check("basic grant cycles", 64'(gcycles), 64'd3);
        check("basic data cnt", 64'(data_pkt_cnt), 64'd1);
        check("basic idle after", 64'(flags_now()), 64'h0);

        // ---------------- simultaneous requests, table driven ----------------
        for (int i = 0; i < 8; i++) begin
            @(negedge core_clk);
            arb_enable     = vecs[i].en;
            ctrl_if.tvalid = vecs[i].cv;
            ctrl_if.tlast  = vecs[i].cl;
            ctrl_if.tdata  = vecs[i].cd;
            data_if.tvalid = vecs[i].dv;
            data_if.tlast  = vecs[i].dl;
            data_if.tdata  = vecs[i].dd;
            out_if.tready  = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d flags", i), 64'(flags_now()), 64'(vecs[i].e_flags));
            check($sformatf("vec%0d tdata", i), out_if.tdata, vecs[i].e_od);
        end
        check("simul cnts", {ctrl_pkt_cnt, data_pkt_cnt}, {32'd1, 32'd2});

        // ---------------- starvation bound ----------------
        @(negedge core_clk);
        ctrl_if.tvalid = 1'b1;
        ctrl_if.tlast  = 1'b1;
        ctrl_if.tdata  = C1;
        data_if.tvalid = 1'b1;
        data_if.tlast  = 1'b1;
        data_if.tdata  = D1;
        out_if.tready  = 1'b1;
        seq = "";
        ng  = 0;
        for (int n = 0; n < 60 && ng < 10; n++) begin
            #1;
            if (grant_ctrl) begin
                seq = {seq, "C"};
                ng++;
            end else if (grant_data) begin
                seq = {seq, "D"};
                ng++;
            end
            @(negedge core_clk);
        end
        quiet();
        n_tests++;
        if (seq != "CCCCDCCCCD") begin
            n_fail++;
            $display("FAIL starve order: got %s, expected CCCCDCCCCD", seq);
        end
        #1;
        check("starve cnts", {ctrl_pkt_cnt, data_pkt_cnt}, {32'd9, 32'd4});

        // ---------------- backpressure 1010 on a 4-beat ctrl packet ----------------
        bi     = 0;
        done_n = -1;
        for (int n = 0; n < 20 && bi < 4; n++) begin
            @(negedge core_clk);
            ctrl_if.tvalid = 1'b1;
            ctrl_if.tdata  = beats[bi];
            ctrl_if.tlast  = (bi == 3);
            out_if.tready  = n[0];
            #1;
            if (grant_ctrl) begin
                check("bp readies", 64'({ctrl_if.tready, data_if.tready}),
                      64'({out_if.tready, 1'b0}));
            end
            if (out_if.tvalid && out_if.tready) begin
                check("bp beat", out_if.tdata, beats[bi]);
                if (bi == 3) done_n = n;
                bi++;
            end
        end
        check("bp completion cycle", 64'(done_n), 64'd7);
        @(negedge core_clk);
        quiet();
        out_if.tready = 1'b1;
        #1;
        check("bp ctrl cnt", 64'(ctrl_pkt_cnt), 64'd10);

        // ---------------- arb_enable drop mid-packet ----------------
        bi = 0;
        for (int n = 0; n < 20 && bi < 5; n++) begin
            @(negedge core_clk);
            arb_enable     = (bi < 1);
            ctrl_if.tvalid = (n != 0);
            ctrl_if.tlast  = 1'b1;
            ctrl_if.tdata  = C2;
            data_if.tvalid = 1'b1;
            data_if.tdata  = beats[bi];
            data_if.tlast  = (bi == 4);
            #1;
            if (out_if.tvalid && out_if.tready) begin
                check("en beat", out_if.tdata, beats[bi]);
                check("en grant", 64'({grant_ctrl, grant_data}), 64'b01);
                bi++;
            end
        end
        check("en beats done", 64'(bi), 64'd5);
        for (int n = 0; n < 3; n++) begin
            @(negedge core_clk);
            data_if.tdata = beats[0];
            data_if.tlast = 1'b0;
            #1;
            check("en hold idle", 64'({grant_ctrl, grant_data, out_if.tvalid}), 64'h0);
        end
        @(negedge core_clk);
        arb_enable = 1'b1;
        #1;
        check("en idle before edge", 64'({grant_ctrl, grant_data}), 64'h0);
        @(negedge core_clk);
        #1;
        check("en ctrl next", 64'({grant_ctrl, grant_data}), 64'b10);
        check("en ctrl data", out_if.tdata, C2);
        @(negedge core_clk);
        quiet();
        #1;
        check("en cnts", {ctrl_pkt_cnt, data_pkt_cnt}, {32'd11, 32'd5});

        // ---------------- reset mid-packet ----------------
        for (int n = 0; n < 3; n++) begin
            @(negedge core_clk);
            data_if.tvalid    = 1'b1;
            data_if.tdata     = beats[n];
            data_if.tlast     = 1'b0;
            data_if.ip_dest   = 32'h0A00_0001;
            data_if.port_dest = 16'd1234;
            if (n == 2) core_rst_n = 1'b0;
        end
        @(negedge core_clk);
        #1;
        check("rst flags", 64'(flags_now()), 64'h0);
        check("rst tdata", out_if.tdata, 64'h0);
        check("rst keep", 64'(out_if.tkeep), 64'h0);
        check("rst ip/port", 64'({out_if.ip_dest, out_if.port_dest}), 64'h0);
        check("rst cnts", {ctrl_pkt_cnt, data_pkt_cnt}, 64'h0);
        @(negedge core_clk);
        quiet();
        core_rst_n = 1'b1;
        @(negedge core_clk);
        ctrl_if.tvalid    = 1'b1;
        ctrl_if.tlast     = 1'b1;
        ctrl_if.tdata     = 64'h7777_0000_0000_0007;
        ctrl_if.ip_dest   = 32'h0A00_00FE;
        ctrl_if.port_dest = 16'd4321;
        @(negedge core_clk);
        #1;
        check("post-rst grant", 64'(flags_now()), 64'(6'b101110));
        check("post-rst tdata", out_if.tdata, 64'h7777_0000_0000_0007);
        check("post-rst ip/port", 64'({out_if.ip_dest, out_if.port_dest}),
              64'({32'h0A00_00FE, 16'd4321}));
        @(negedge core_clk);
        quiet();
        #1;
        check("post-rst cnts", {ctrl_pkt_cnt, data_pkt_cnt}, {32'd1, 32'd0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop so a broken DUT can never hang the run.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
